// File: rtl/sha256_block_padder.sv
// Streams message bytes into 512-bit SHA-256 blocks, appending the 0x80
// terminator, zero fill and the 64-bit big-endian message bit length.
module sha256_block_padder #(
    parameter int IN_BYTES = 4,
    parameter int NB_W     = $clog2(IN_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [8*IN_BYTES-1:0] s_data,
    input  logic                  s_last,
    input  logic [NB_W-1:0]       s_nbytes,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [511:0]          blk_data,
    output logic                  blk_first,
    output logic                  blk_last,
    output logic                  busy
);
    localparam int SLOTS = 64 / IN_BYTES;
    localparam int SH    = $clog2(IN_BYTES);

    typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

    state_t                state_q;
    logic [511:0]          buf_q;
    logic [6:0]            idx_q;
    logic [60:0]           cnt_q;
    logic                  first_q;
    logic                  last_q;
    logic                  pend_q;
    logic                  owe_q;
    logic                  busy_q;

    logic [NB_W-1:0]       n_d;
    logic [6:0]            p_d;
    logic [60:0]           cnt_d;
    logic [63:0]           len_d;
    logic [8*IN_BYTES-1:0] din_d;
    logic [511:0]          fill_d;
    logic [511:0]          pad_d;

    always_comb begin
        n_d = NB_W'(IN_BYTES);
        if (s_last && (s_nbytes < NB_W'(IN_BYTES))) begin
            n_d = s_nbytes;
        end
        p_d   = idx_q + 7'(n_d);
        cnt_d = cnt_q + 61'(n_d);
        len_d = {cnt_d, 3'b000};

        // Bytes beyond the valid count of a last beat are forced to zero.
        din_d = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            din_d[8*(IN_BYTES-1-k) +: 8] = (NB_W'(k) < n_d) ? s_data[8*(IN_BYTES-1-k) +: 8] : 8'h00;
        end

        fill_d = buf_q;
        for (int j = 0; j < SLOTS; j++) begin
            if ((idx_q[5:0] >> SH) == 6'(j)) begin
                fill_d[511-8*IN_BYTES*j -: 8*IN_BYTES] = din_d;
            end
        end
        if (s_last) begin
            for (int b = 0; b < 64; b++) begin
                if (p_d == 7'(b)) begin
                    fill_d[511-8*b -: 8] = 8'h80;
                end
            end
            if (p_d <= 7'd55) begin
                fill_d[63:0] = len_d;
            end
        end

        pad_d          = '0;
        pad_d[511:504] = owe_q ? 8'h80 : 8'h00;
        pad_d[63:0]    = {cnt_q, 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            buf_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            owe_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (s_valid) begin
                        buf_q  <= fill_d;
                        cnt_q  <= cnt_d;
                        busy_q <= 1'b1;
                        if (s_last) begin
                            state_q <= EMIT;
                            last_q  <= (p_d <= 7'd55);
                            pend_q  <= (p_d > 7'd55);
                            owe_q   <= (p_d == 7'd64);
                        end else if (idx_q == 7'(64 - IN_BYTES)) begin
                            state_q <= EMIT;
                            last_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 7'(IN_BYTES);
                        end
                    end
                end
                EMIT, PADBLK: begin
                    if (blk_ready) begin
                        if (state_q == EMIT && pend_q) begin
                            // Length did not fit: follow with a dedicated padding block.
                            buf_q   <= pad_d;
                            state_q <= PADBLK;
                            first_q <= 1'b0;
                            last_q  <= 1'b1;
                            pend_q  <= 1'b0;
                            owe_q   <= 1'b0;
                        end else if (last_q) begin
                            state_q <= FILL;
                            buf_q   <= '0;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            first_q <= 1'b1;
                            last_q  <= 1'b0;
                            pend_q  <= 1'b0;
                            owe_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= FILL;
                            buf_q   <= '0;
                            idx_q   <= '0;
                            first_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign s_ready   = (state_q == FILL);
    assign blk_valid = (state_q != FILL);
    assign blk_data  = buf_q;
    assign blk_first = first_q;
    assign blk_last  = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench for sha256_block_padder at IN_BYTES = 1, 4 and 8, checked
// against hand-computed blocks and a byte-queue reference padder.
module tb_sha256_block_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   sel;
    int           ib;
    logic         sv;
    logic [63:0]  sd;
    logic         sl;
    logic [3:0]   snb;
    logic         brdy;
    logic [2:0]   s_ready_w, blk_valid_w, blk_first_w, blk_last_w, busy_w;
    logic [511:0] bd1, bd4, bd8;
    logic [511:0] cur_data;
    logic         cur_valid, cur_first, cur_last, cur_sready;

    int   total = 0;
    int   bad   = 0;
    blk_t got_q[$];
    blk_t exp_q[$];

    localparam logic [511:0] ABC = {32'h61626380, 416'h0, 64'h18};

    always #5 clk = ~clk;

    sha256_block_padder #(.IN_BYTES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv && sel == 2'd0), .s_ready(s_ready_w[0]),
        .s_data(sd[63:56]), .s_last(sl), .s_nbytes(snb[0:0]), .blk_valid(blk_valid_w[0]),
        .blk_ready(brdy), .blk_data(bd1), .blk_first(blk_first_w[0]), .blk_last(blk_last_w[0]),
        .busy(busy_w[0]));
    sha256_block_padder #(.IN_BYTES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv && sel == 2'd1), .s_ready(s_ready_w[1]),
        .s_data(sd[63:32]), .s_last(sl), .s_nbytes(snb[2:0]), .blk_valid(blk_valid_w[1]),
        .blk_ready(brdy), .blk_data(bd4), .blk_first(blk_first_w[1]), .blk_last(blk_last_w[1]),
        .busy(busy_w[1]));
    sha256_block_padder #(.IN_BYTES(8)) u8 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv && sel == 2'd2), .s_ready(s_ready_w[2]),
        .s_data(sd), .s_last(sl), .s_nbytes(snb), .blk_valid(blk_valid_w[2]),
        .blk_ready(brdy), .blk_data(bd8), .blk_first(blk_first_w[2]), .blk_last(blk_last_w[2]),
        .busy(busy_w[2]));

    assign cur_data   = (sel == 2'd0) ? bd1 : (sel == 2'd1) ? bd4 : bd8;
    assign cur_valid  = (sel == 2'd0) ? blk_valid_w[0] : (sel == 2'd1) ? blk_valid_w[1] : blk_valid_w[2];
    assign cur_first  = (sel == 2'd0) ? blk_first_w[0] : (sel == 2'd1) ? blk_first_w[1] : blk_first_w[2];
    assign cur_last   = (sel == 2'd0) ? blk_last_w[0]  : (sel == 2'd1) ? blk_last_w[1]  : blk_last_w[2];
    assign cur_sready = (sel == 2'd0) ? s_ready_w[0]   : (sel == 2'd1) ? s_ready_w[1]   : s_ready_w[2];

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic bq_t mkmsg(input int n, input int seed);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'((i * 37 + seed * 11 + 5) & 255));
        return q;
    endfunction

    // Reference padder: append 0x80, zero to 56 mod 64, then 64-bit bit length.
    task automatic model(input bq_t m);
        bq_t         p;
        logic [63:0] bits;
        int          nblk;
        blk_t        e;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(m.size()) << 3;
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.d = '0;
            for (int k = 0; k < 64; k++) e.d = {e.d[503:0], p[64*b+k]};
            e.f = (b == 0);
            e.l = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input bq_t m, input bit term);
        int n, pos, nb, beats, t, sh;
        n     = m.size();
        pos   = 0;
        beats = term ? ((n == 0) ? 1 : (n + ib - 1) / ib) : n / ib;
        @(posedge clk);
        #1;
        for (int b = 0; b < beats; b++) begin
            nb = (n - pos < ib) ? n - pos : ib;
            sd = {$urandom, $urandom};
            for (int k = 0; k < nb; k++) begin
                sh = 56 - 8 * k;
                sd = (sd & ~(64'hFF << sh)) | (64'(m[pos+k]) << sh);
            end
            sl  = term && (b == beats - 1);
            snb = 4'(nb);
            sv  = 1'b1;
            t   = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!cur_sready && t < 1000);
            if (t >= 1000) chk("send_timeout", cur_sready, 1);
            @(posedge clk);
            #1;
            pos += nb;
        end
        sv = 1'b0;
        sl = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: stall first block 5 cycles
    task automatic recv(input int nexp, input int mode);
        int           t, got_n, stall;
        logic [511:0] held;
        blk_t         g;
        t = 0; got_n = 0; stall = 0; held = '0;
        while (got_n < nexp && t < 3000) begin
            @(negedge clk);
            t++;
            if (mode == 2 && got_n == 0 && cur_valid && stall < 5) begin
                brdy = 1'b0;
                if (stall == 0) held = cur_data;
                else chk("stall_data", cur_data, held);
                chk("stall_sready", cur_sready, 0);
                stall++;
            end else begin
                brdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (cur_valid && brdy) begin
                if (mode == 2 && got_n == 0) chk("stall_hs_data", cur_data, held);
                g.d = cur_data;
                g.f = cur_first;
                g.l = cur_last;
                got_q.push_back(g);
                got_n++;
            end
        end
        if (got_n < nexp) chk("recv_timeout", got_n, nexp);
    endtask

    task automatic compare(input string tag);
        int n;
        chk($sformatf("%s_nblk", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
            chk($sformatf("%s_first%0d", tag, i), got_q[i].f, exp_q[i].f);
            chk($sformatf("%s_last%0d", tag, i), got_q[i].l, exp_q[i].l);
        end
        @(negedge clk);
        chk($sformatf("%s_idle_busy", tag), busy_w, 3'b000);
    endtask

    task automatic setsel(input logic [1:0] s);
        sel = s;
        ib  = (s == 2'd0) ? 1 : (s == 2'd1) ? 4 : 8;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input logic [1:0] s, input bq_t m, input int mode, input string tag);
        setsel(s);
        model(m);
        fork
            send(m, 1'b1);
            recv(exp_q.size(), mode);
        join
        compare(tag);
    endtask

    task automatic run2(input logic [1:0] s, input bq_t a, input bq_t b, input string tag);
        setsel(s);
        model(a);
        model(b);
        fork
            begin
                send(a, 1'b1);
                send(b, 1'b1);
            end
            recv(exp_q.size(), 1);
        join
        compare(tag);
    endtask

    initial begin
        bq_t abc;
        bq_t empty;
        bq_t m;
        abc   = '{8'h61, 8'h62, 8'h63};
        rst_n = 1'b0;
        sel   = 2'd0;
        ib    = 1;
        sv    = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        snb   = '0;
        brdy  = 1'b0;

        #12;
        chk("rst_valid", blk_valid_w, 3'b000);
        chk("rst_first", blk_first_w, 3'b111);
        chk("rst_last", blk_last_w, 3'b000);
        chk("rst_busy", busy_w, 3'b000);
        chk("rst_data", bd1 | bd4 | bd8, 512'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_sready", s_ready_w, 3'b111);

        run(2'd0, abc, 0, "abc1");
        chk("abc1_hand", got_q[0].d, ABC);

        run(2'd1, mkmsg(55, 1), 2, "m55");
        chk("m55_pad", got_q[0].d[71:64], 8'h80);
        chk("m55_len", got_q[0].d[63:0], 64'h1B8);

        run(2'd1, mkmsg(56, 2), 0, "m56");
        chk("m56_blk1", got_q[1].d, 512'h1C0);
        chk("m56_last0", got_q[0].l, 0);

        run(2'd2, mkmsg(64, 3), 0, "m64");
        chk("m64_blk1", got_q[1].d, {8'h80, 440'h0, 64'h200});
        chk("m64_first1", got_q[1].f, 0);

        run(2'd1, empty, 0, "empty4");
        chk("empty4_hand", got_q[0].d, {8'h80, 504'h0});
        run(2'd2, empty, 0, "empty8");
        run(2'd0, empty, 0, "empty1");

        run2(2'd1, mkmsg(61, 4), mkmsg(120, 5), "b2b4");
        run2(2'd2, mkmsg(63, 6), mkmsg(9, 7), "b2b8");
        run2(2'd0, mkmsg(57, 8), mkmsg(3, 9), "b2b1");

        setsel(2'd0);
        m = mkmsg(30, 10);
        send(m, 1'b0);
        @(negedge clk);
        chk("mid_busy", busy_w[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_w[0], 0);
        chk("mid_rst_first", blk_first_w[0], 1);
        chk("mid_rst_data", bd1, 512'h0);
        chk("mid_rst_sready", s_ready_w[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(2'd0, abc, 0, "abc2");
        chk("abc2_hand", got_q[0].d, ABC);
        @(negedge clk);
        chk("abc2_no_extra", blk_valid_w[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
